// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a skewed-timing ALU datapath.
// One transaction in flight; the result returns on a valid/ready port tagged with the requester id.
module alu_arbiter #(
    parameter logic       RR_START = 1'b0,
    parameter logic [1:0] IDLE_OP  = 2'd0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [7:0] req0_in,
    input  logic [1:0] req0_op,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [7:0] req1_in,
    input  logic [1:0] req1_op,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [8:0] rsp_data,
    output logic [7:0] dp_in,
    output logic [1:0] dp_op,
    input  logic [8:0] dp_out,
    output logic       busy,
    output logic [7:0] done0_cnt,
    output logic [7:0] done1_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_EXEC,
        S_CAPT,
        S_RESP
    } state_t;

    state_t     r_state;
    logic       r_prio;
    logic       r_id;
    logic [1:0] r_op;

    logic       w_idle;
    logic       w_grant0;
    logic       w_grant1;

    // The holder of r_prio only matters when both requesters are valid.
    assign w_idle     = (r_state == S_IDLE) && !reset;
    assign w_grant0   = w_idle && req0_valid && (!req1_valid || (r_prio == 1'b0));
    assign w_grant1   = w_idle && req1_valid && (!req0_valid || (r_prio == 1'b1));
    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;
    assign busy       = (r_state != S_IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_prio    <= RR_START;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= 9'd0;
            dp_in     <= 8'd0;
            dp_op     <= IDLE_OP;
            done0_cnt <= 8'd0;
            done1_cnt <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant0 || w_grant1) begin
                        r_id    <= w_grant1;
                        r_op    <= w_grant1 ? req1_op : req0_op;
                        dp_in   <= w_grant1 ? req1_in : req0_in;
                        dp_op   <= IDLE_OP;
                        r_prio  <= w_grant0;
                        r_state <= S_LOAD;
                    end
                end
                // The datapath registers dp_in one cycle before it consumes dp_op.
                S_LOAD: begin
                    dp_op   <= r_op;
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    dp_op   <= IDLE_OP;
                    r_state <= S_CAPT;
                end
                S_CAPT: begin
                    rsp_data  <= dp_out;
                    rsp_id    <= r_id;
                    rsp_valid <= 1'b1;
                    r_state   <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        r_state   <= S_IDLE;
                        if (rsp_id) begin
                            done1_cnt <= done1_cnt + 8'd1;
                        end else begin
                            done0_cnt <= done0_cnt + 8'd1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural datapath, directed vector table, corner sequences
// and a randomized two-requester run checked against a transaction-level model.
module tb_alu_arbiter;

    localparam logic       RR_START = 1'b0;
    localparam logic [1:0] IDLE_OP  = 2'd0;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic       req0_ready, req1_ready;
    logic [7:0] req0_in = 8'd0, req1_in = 8'd0;
    logic [1:0] req0_op = 2'd0, req1_op = 2'd0;
    logic       rsp_valid, rsp_id, busy;
    logic       rsp_ready = 1'b1;
    logic [8:0] rsp_data;
    logic [7:0] dp_in;
    logic [1:0] dp_op;
    logic [8:0] dp_out = 9'd0;
    logic [7:0] done0_cnt, done1_cnt;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int cnt0 = 0, cnt1 = 0;

    alu_arbiter #(.RR_START(RR_START), .IDLE_OP(IDLE_OP)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_in(req0_in), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_in(req1_in), .req1_op(req1_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .dp_in(dp_in), .dp_op(dp_op), .dp_out(dp_out), .busy(busy),
        .done0_cnt(done0_cnt), .done1_cnt(done1_cnt)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [1:0] op);
        case (op)
            2'd0:    return 9'(a);
            2'd1:    return 9'(a) + 9'd2;
            2'd2:    return 9'(a) * 9'd2;
            default: return 9'($countones(a));
        endcase
    endfunction

    // Datapath: result after edge E uses dp_in from edge E-1 and dp_op from edge E.
    logic [7:0] dp_in_d = 8'd0;
    always @(posedge clock) begin
        dp_out  <= alu_f(dp_in_d, dp_op);
        dp_in_d <= dp_in;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic set_req(input bit id, input bit v, input logic [7:0] a, input logic [1:0] op);
        if (id) begin
            req1_valid = v; req1_in = a; req1_op = op;
        end else begin
            req0_valid = v; req0_in = a; req0_op = op;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        cnt0 = 0;
        cnt1 = 0;
    endtask

    // Returns the cycle of acceptance, or -1 on timeout.
    task automatic wait_ready(input bit id, output int acc);
        acc = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if ((id ? req1_ready : req0_ready) == 1'b1) begin
                acc = cyc;
                break;
            end
        end
        chk("ready_seen", int'(acc >= 0), 1);
    endtask

    task automatic wait_rsp(output int at);
        at = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (rsp_valid) begin
                at = cyc;
                break;
            end
        end
        chk("rsp_seen", int'(at >= 0), 1);
    endtask

    // Full transaction with rsp_ready=1; starts and ends just after a posedge.
    task automatic txn(input bit id, input logic [7:0] a, input logic [1:0] op);
        int acc, at;
        rsp_ready = 1'b1;
        set_req(id, 1'b1, a, op);
        wait_ready(id, acc);
        chk("other_ready_low", int'(id ? req0_ready : req1_ready), 0);
        @(posedge clock); #1;
        @(negedge clock);
        chk("ready_one_cycle", int'(id ? req1_ready : req0_ready), 0);
        @(posedge clock); #1;
        set_req(id, 1'b0, a, op);
        wait_rsp(at);
        chk("latency", at - acc, 4);
        chk("rsp_data", int'(rsp_data), int'(alu_f(a, op)));
        chk("rsp_id", int'(rsp_id), int'(id));
        @(posedge clock); #1;
        if (id) cnt1++; else cnt0++;
        @(negedge clock);
        chk("rsp_valid_drop", int'(rsp_valid), 0);
        chk("done_cnt", int'(id ? done1_cnt : done0_cnt), (id ? cnt1 : cnt0) % 256);
        @(posedge clock); #1;
    endtask

    typedef struct {
        logic       id;
        logic [7:0] a;
        logic [1:0] op;
        int         exp;
    } vec_t;

    vec_t vecs[12];
    logic [9:0] q[$];

    initial begin
        int acc, at;
        int g_id[$], g_cyc[$], r_id[$];
        bit m_prio, acc0, acc1, pv;
        logic [9:0] pd, e;
        int n_rsp;

        vecs[0]  = '{1'b0, 8'd9,   2'd1, 11};
        vecs[1]  = '{1'b0, 8'd9,   2'd2, 18};
        vecs[2]  = '{1'b0, 8'd9,   2'd3, 2};
        vecs[3]  = '{1'b0, 8'd143, 2'd3, 5};
        vecs[4]  = '{1'b0, 8'd255, 2'd2, 510};
        vecs[5]  = '{1'b0, 8'd255, 2'd1, 257};
        vecs[6]  = '{1'b1, 8'd0,   2'd3, 0};
        vecs[7]  = '{1'b1, 8'd255, 2'd3, 8};
        vecs[8]  = '{1'b1, 8'd0,   2'd1, 2};
        vecs[9]  = '{1'b1, 8'd128, 2'd2, 256};
        vecs[10] = '{1'b1, 8'd77,  2'd0, 77};
        vecs[11] = '{1'b0, 8'd254, 2'd1, 256};

        // Reset state, with a request already pending
        reset = 1'b1;
        set_req(1'b0, 1'b1, 8'd9, 2'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_ready0", int'(req0_ready), 0);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_rsp_id", int'(rsp_id), 0);
        chk("rst_rsp_data", int'(rsp_data), 0);
        chk("rst_dp_in", int'(dp_in), 0);
        chk("rst_dp_op", int'(dp_op), int'(IDLE_OP));
        chk("rst_busy", int'(busy), 0);
        chk("rst_done0", int'(done0_cnt), 0);
        chk("rst_done1", int'(done1_cnt), 0);
        @(posedge clock); #1;
        req0_valid = 1'b0;
        reset = 1'b0;
        txn(1'b0, 8'd9, 2'd0);

        // Vector table
        for (int i = 0; i < 12; i++) begin
            chk("vec_table", int'(alu_f(vecs[i].a, vecs[i].op)), vecs[i].exp);
            txn(vecs[i].id, vecs[i].a, vecs[i].op);
        end

        // Both valid continuously: grants alternate starting with RR_START
        do_reset();
        set_req(1'b0, 1'b1, 8'd3, 2'd1);
        set_req(1'b1, 1'b1, 8'd4, 2'd2);
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (req0_ready || req1_ready) begin
                g_id.push_back(int'(req1_ready));
                g_cyc.push_back(cyc);
            end
            if (rsp_valid && rsp_ready) begin
                r_id.push_back(int'(rsp_id));
                chk("rr_data", int'(rsp_data), rsp_id ? 8 : 5);
            end
        end
        chk("rr_grant_count", int'(g_id.size() >= 4 && r_id.size() >= 4), 1);
        for (int i = 0; i < 4 && i < g_id.size() && i < r_id.size(); i++) begin
            chk("rr_grant_id", g_id[i], (i % 2 == 0) ? int'(RR_START) : int'(!RR_START));
            chk("rr_rsp_id", r_id[i], g_id[i]);
            if (i > 0) chk("rr_spacing", g_cyc[i] - g_cyc[i-1], 5);
        end
        @(posedge clock); #1;

        // Response stall with the other requester waiting
        do_reset();
        rsp_ready = 1'b0;
        set_req(1'b0, 1'b1, 8'd20, 2'd1);
        wait_ready(1'b0, acc);
        @(posedge clock); #1;
        set_req(1'b0, 1'b0, 8'd0, 2'd0);
        set_req(1'b1, 1'b1, 8'd5, 2'd3);
        wait_rsp(at);
        chk("stall_data0", int'(rsp_data), 22);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk("stall_valid", int'(rsp_valid), 1);
            chk("stall_data", int'(rsp_data), 22);
            chk("stall_id", int'(rsp_id), 0);
            chk("stall_ready1", int'(req1_ready), 0);
        end
        @(posedge clock); #1;
        rsp_ready = 1'b1;
        @(negedge clock);
        chk("stall_hs_ready1", int'(req1_ready), 0);
        @(negedge clock);
        chk("stall_next_grant1", int'(req1_ready), 1);
        chk("stall_done0", int'(done0_cnt), 1);
        chk("stall_valid_low", int'(rsp_valid), 0);
        @(posedge clock); #1;
        set_req(1'b1, 1'b0, 8'd0, 2'd0);
        wait_rsp(at);
        chk("stall_r1_data", int'(rsp_data), 2);
        chk("stall_r1_id", int'(rsp_id), 1);
        @(posedge clock); #1;
        @(negedge clock);
        chk("stall_done1", int'(done1_cnt), 1);
        @(posedge clock); #1;

        // Reset while in EXEC
        do_reset();
        set_req(1'b0, 1'b1, 8'd7, 2'd2);
        wait_ready(1'b0, acc);
        @(posedge clock); #1;
        set_req(1'b0, 1'b0, 8'd0, 2'd0);
        @(posedge clock); #1;
        @(negedge clock);
        chk("exec_busy", int'(busy), 1);
        chk("exec_dp_op", int'(dp_op), 2);
        chk("exec_dp_in", int'(dp_in), 7);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        chk("abort_busy", int'(busy), 0);
        chk("abort_dp_op", int'(dp_op), int'(IDLE_OP));
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            chk("abort_no_rsp", int'(rsp_valid), 0);
        end
        chk("abort_done0", int'(done0_cnt), 0);
        @(posedge clock); #1;
        txn(1'b0, 8'd100, 2'd1);

        // Counter wrap on requester 1
        do_reset();
        for (int i = 0; i < 256; i++) txn(1'b1, 8'($urandom), 2'($urandom));
        chk("wrap_done1", int'(done1_cnt), 0);
        chk("wrap_done0", int'(done0_cnt), 0);

        // Randomized traffic against a transaction-level model
        do_reset();
        q.delete();
        m_prio = RR_START;
        acc0 = 1'b0; acc1 = 1'b0; pv = 1'b0; pd = '0;
        n_rsp = 0;
        for (int c = 0; c < 1500; c++) begin
            if (acc0 || !req0_valid) begin
                if ($urandom_range(0, 2) != 0) set_req(1'b0, 1'b1, 8'($urandom), 2'($urandom));
                else req0_valid = 1'b0;
            end
            if (acc1 || !req1_valid) begin
                if ($urandom_range(0, 2) != 0) set_req(1'b1, 1'b1, 8'($urandom), 2'($urandom));
                else req1_valid = 1'b0;
            end
            acc0 = 1'b0; acc1 = 1'b0;
            rsp_ready = ($urandom_range(0, 3) != 0);
            @(negedge clock);
            chk("rnd_busy", int'(busy), int'(q.size() != 0));
            if (pv) begin
                chk("rnd_rsp_hold", int'({rsp_valid, rsp_id, rsp_data}), int'({1'b1, pd}));
            end
            if (q.size() == 0 && (req0_valid || req1_valid)) begin
                chk("rnd_grant", int'({req1_ready, req0_ready}),
                    (req0_valid && req1_valid) ? (m_prio ? 2 : 1) : (req1_valid ? 2 : 1));
                if (req0_ready) begin
                    q.push_back({1'b0, alu_f(req0_in, req0_op)});
                    acc0 = 1'b1; m_prio = 1'b1;
                end else if (req1_ready) begin
                    q.push_back({1'b1, alu_f(req1_in, req1_op)});
                    acc1 = 1'b1; m_prio = 1'b0;
                end
            end else begin
                chk("rnd_no_grant", int'({req1_ready, req0_ready}), 0);
            end
            pv = rsp_valid && !rsp_ready;
            pd = {rsp_id, rsp_data};
            if (rsp_valid && rsp_ready) begin
                if (q.size() == 0) begin
                    chk("rnd_unexpected_rsp", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("rnd_rsp", int'({rsp_id, rsp_data}), int'(e));
                    chk("rnd_cnt", int'(rsp_id ? done1_cnt : done0_cnt), (rsp_id ? cnt1 : cnt0) % 256);
                    if (rsp_id) cnt1++; else cnt0++;
                    n_rsp++;
                end
            end
            @(posedge clock); #1;
        end
        chk("rnd_progress", int'(n_rsp > 50), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
